// File: rtl/jtag_host_if.sv
// Request/response and JTAG pin bundle for jtag_host_shifter.
// The shifter connects through the slave modport. The requester, which also
// owns the TAP pins, connects through the master modport.
// Optional macro JTAG_HOST_IR_CHECK_EN adds the ir_err status signal.
interface jtag_host_if #(
  parameter int unsigned IR_WIDTH = 8,
  parameter int unsigned DR_MAX   = 32
);
  localparam int unsigned LEN_W = $clog2(DR_MAX + 1);

  logic                start;
  logic [1:0]          op;
  logic [IR_WIDTH-1:0] ir_in;
  logic [DR_MAX-1:0]   dr_in;
  logic [LEN_W-1:0]    dr_len;
  logic                busy;
  logic                done;
  logic [DR_MAX-1:0]   dr_out;
  logic                tck;
  logic                tms;
  logic                tdi;
  logic                tdo;
`ifdef JTAG_HOST_IR_CHECK_EN
  logic                ir_err;

  modport master (
    output start, op, ir_in, dr_in, dr_len, tdo,
    input  busy, done, dr_out, tck, tms, tdi, ir_err
  );

  modport slave (
    input  start, op, ir_in, dr_in, dr_len, tdo,
    output busy, done, dr_out, tck, tms, tdi, ir_err
  );
`else
  modport master (
    output start, op, ir_in, dr_in, dr_len, tdo,
    input  busy, done, dr_out, tck, tms, tdi
  );

  modport slave (
    input  start, op, ir_in, dr_in, dr_len, tdo,
    output busy, done, dr_out, tck, tms, tdi
  );
`endif
endinterface

// File: rtl/jtag_host_shifter.sv
// JTAG initiator: runs TAP reset, IR scan and DR scan ops from Run-Test/Idle,
// driving TCK/TMS/TDI and capturing TDO. One FSM step is one TCK period.
// Optional macro JTAG_HOST_IR_CHECK_EN enables checking of the IR capture pattern.
module jtag_host_shifter #(
  parameter int unsigned IR_WIDTH = 8,
  parameter int unsigned DR_MAX   = 32,
  parameter int unsigned CLK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  jtag_host_if.slave  bus
);

  localparam int unsigned SH_W  = (DR_MAX > IR_WIDTH) ? DR_MAX : IR_WIDTH;
  localparam int unsigned CNT_W = $clog2(SH_W + 1);
  localparam int unsigned IDX_W = (SH_W > 1) ? $clog2(SH_W) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_RST = 2'd0;
  localparam logic [1:0] OP_IR  = 2'd1;
  localparam logic [1:0] OP_DR  = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;

  // TMS preamble patterns, step 0 in bit 0
  localparam logic [5:0] PRE_RST = 6'b011111;
  localparam logic [5:0] PRE_IR  = 6'b000011;
  localparam logic [5:0] PRE_DR  = 6'b000001;

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [SH_W-1:0]   cap_q, cap_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic [2:0]        step_q, step_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DR_MAX-1:0] dr_out_q, dr_out_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
`ifdef JTAG_HOST_IR_CHECK_EN
  logic              ir_err_q, ir_err_d;
`endif

  logic [5:0]        pre_pat;
  logic [2:0]        pre_last;
  logic [2:0]        step_n;
  logic [CNT_W-1:0]  bit_n;
  logic [CNT_W-1:0]  len_eff;
  logic              half_end;
  logic              ticking;
  logic              rise;
  logic              fall;
  logic              finish;

  // Preamble TMS pattern and last step index for the latched op
  always_comb begin
    pre_pat  = PRE_DR;
    pre_last = 3'd2;
    case (op_q)
      OP_RST: begin
        pre_pat  = PRE_RST;
        pre_last = 3'd5;
      end
      OP_IR: begin
        pre_pat  = PRE_IR;
        pre_last = 3'd3;
      end
      default: begin
        pre_pat  = PRE_DR;
        pre_last = 3'd2;
      end
    endcase
  end

  // Requested DR length clamped to 1..DR_MAX
  always_comb begin
    if (bus.dr_len == '0) begin
      len_eff = CNT_W'(1);
    end else if (32'(bus.dr_len) > DR_MAX) begin
      len_eff = CNT_W'(DR_MAX);
    end else begin
      len_eff = CNT_W'(bus.dr_len);
    end
  end

  // TCK divider timing: tck toggles at the end of every CLK_DIV-clk half period
  always_comb begin
    ticking  = ((state_q == S_PRE) && (op_q != OP_NOP)) ||
               (state_q == S_SHIFT) || (state_q == S_POST);
    half_end = (div_q == DIV_W'(CLK_DIV - 1));
    rise     = ticking && half_end && !tck_q;
    fall     = ticking && half_end && tck_q;
    step_n   = step_q + 3'd1;
    bit_n    = bit_q + CNT_W'(1);
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sh_d     = sh_q;
    cap_d    = cap_q;
    len_d    = len_q;
    bit_d    = bit_q;
    step_d   = step_q;
    div_d    = div_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dr_out_d = dr_out_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    finish   = 1'b0;
`ifdef JTAG_HOST_IR_CHECK_EN
    ir_err_d = ir_err_q;
`endif

    if (ticking) begin
      if (half_end) begin
        div_d = '0;
        tck_d = !tck_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PRE;
          op_d    = bus.op;
          busy_d  = 1'b1;
          div_d   = '0;
          step_d  = '0;
          bit_d   = '0;
          cap_d   = '0;
          tck_d   = 1'b0;
          tdi_d   = 1'b0;
          if (bus.op == OP_IR) begin
            sh_d  = SH_W'(bus.ir_in);
            len_d = CNT_W'(IR_WIDTH);
          end else begin
            sh_d  = SH_W'(bus.dr_in);
            len_d = len_eff;
          end
          if (bus.op != OP_NOP) begin
            tms_d = 1'b1;
          end
        end
      end

      S_PRE: begin
        if (op_q == OP_NOP) begin
          finish = 1'b1;
        end else if (fall) begin
          if (step_q == pre_last) begin
            if (op_q == OP_RST) begin
              finish = 1'b1;
            end else begin
              state_d = S_SHIFT;
              bit_d   = '0;
              tms_d   = (len_q == CNT_W'(1));
              tdi_d   = sh_q[0];
            end
          end else begin
            step_d = step_n;
            tms_d  = pre_pat[step_n];
          end
        end
      end

      S_SHIFT: begin
        if (rise) begin
          cap_d[IDX_W'(bit_q)] = bus.tdo;
        end
        if (fall) begin
          if (bit_q == len_q - CNT_W'(1)) begin
            state_d = S_POST;
            step_d  = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_d = bit_n;
            sh_d  = sh_q >> 1;
            tdi_d = sh_d[0];
            tms_d = (bit_n == len_q - CNT_W'(1));
          end
        end
      end

      S_POST: begin
        if (fall) begin
          if (step_q == 3'd1) begin
            finish = 1'b1;
          end else begin
            step_d = 3'd1;
            tms_d  = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      tdi_d   = 1'b0;
      if (op_q == OP_DR) begin
        dr_out_d = cap_q[DR_MAX-1:0];
      end
`ifdef JTAG_HOST_IR_CHECK_EN
      if (op_q == OP_IR) begin
        ir_err_d = (cap_q[1:0] != 2'b01);
      end
`endif
    end
  end

  // State and output registers; reset leaves TCK low with TMS high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_RST;
      sh_q     <= '0;
      cap_q    <= '0;
      len_q    <= '0;
      bit_q    <= '0;
      step_q   <= '0;
      div_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dr_out_q <= '0;
      tck_q    <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
`ifdef JTAG_HOST_IR_CHECK_EN
      ir_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      cap_q    <= cap_d;
      len_q    <= len_d;
      bit_q    <= bit_d;
      step_q   <= step_d;
      div_q    <= div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dr_out_q <= dr_out_d;
      tck_q    <= tck_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
`ifdef JTAG_HOST_IR_CHECK_EN
      ir_err_q <= ir_err_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.dr_out = dr_out_q;
  assign bus.tck    = tck_q;
  assign bus.tms    = tms_q;
  assign bus.tdi    = tdi_q;
`ifdef JTAG_HOST_IR_CHECK_EN
  assign bus.ir_err = ir_err_q;
`endif

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Bench for jtag_host_shifter: behavioural IEEE 1149.1 TAP (IDCODE + BYPASS)
// on the pins, expected results derived from the scan rules with plain arithmetic.
module tb_jtag_host_shifter;

  localparam int unsigned IRW     = 8;
  localparam int unsigned DRM     = 32;
  localparam int unsigned CLK_DIV = 4;
  localparam logic [31:0] IDCODE  = 32'h1234_5679;

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR
  } tap_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtag_host_if #(.IR_WIDTH(IRW), .DR_MAX(DRM)) b ();

  jtag_host_shifter #(.IR_WIDTH(IRW), .DR_MAX(DRM), .CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference state
  logic [7:0]  cur_ir      = 8'h00;
  logic [31:0] exp_dr_out  = 32'h0;
  logic        exp_ir_err  = 1'b0;

  // TAP model
  tap_e        tap        = PAUDR;
  logic [7:0]  ir_reg     = 8'h00;
  logic [7:0]  ir_sr      = 8'h00;
  logic [31:0] id_sr      = 32'h0;
  logic        byp        = 1'b0;
  logic        tdo_m      = 1'b0;
  bit          force_cap0 = 1'b0;
  int          tdi_bad    = 0;
  bit          tms_log[$];

  assign b.tdo = tdo_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tap_e tap_next(input tap_e s, input logic t);
    case (s)
      TLR:     return t ? TLR   : RTI;
      RTI:     return t ? SELDR : RTI;
      SELDR:   return t ? SELIR : CAPDR;
      CAPDR:   return t ? EX1DR : SHDR;
      SHDR:    return t ? EX1DR : SHDR;
      EX1DR:   return t ? UPDR  : PAUDR;
      PAUDR:   return t ? EX2DR : PAUDR;
      EX2DR:   return t ? UPDR  : SHDR;
      UPDR:    return t ? SELDR : RTI;
      SELIR:   return t ? TLR   : CAPIR;
      CAPIR:   return t ? EX1IR : SHIR;
      SHIR:    return t ? EX1IR : SHIR;
      EX1IR:   return t ? UPIR  : PAUIR;
      PAUIR:   return t ? EX2IR : PAUIR;
      EX2IR:   return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  // TAP acts on rising TCK
  always @(posedge b.tck) begin
    tms_log.push_back(b.tms);
    if (tap != SHDR && tap != SHIR && b.tdi !== 1'b0) tdi_bad <= tdi_bad + 1;
    case (tap)
      TLR:   ir_reg <= 8'h00;
      CAPDR: begin id_sr <= IDCODE; byp <= 1'b0; end
      SHDR:  if (ir_reg == 8'h00) id_sr <= {b.tdi, id_sr[31:1]}; else byp <= b.tdi;
      CAPIR: ir_sr <= force_cap0 ? 8'h00 : 8'h01;
      SHIR:  ir_sr <= {b.tdi, ir_sr[7:1]};
      UPIR:  ir_reg <= ir_sr;
      default: ;
    endcase
    tap <= tap_next(tap, b.tms);
  end

  // TAP drives TDO on falling TCK
  always @(negedge b.tck) begin
    case (tap)
      SHDR:    tdo_m <= (ir_reg == 8'h00) ? id_sr[0] : byp;
      SHIR:    tdo_m <= ir_sr[0];
      default: tdo_m <= 1'b0;
    endcase
  end

  task automatic run_op(input logic [1:0] o, input logic [7:0] ir, input logic [31:0] d,
                        input logic [5:0] len, input bit poke);
    int   n, p, cyc, busy_clks, bad, diff;
    bit   exp_q[$];
    logic [63:0] m;
    n = (len == 0) ? 1 : ((len > 32) ? 32 : int'(len));
    exp_q.delete();
    case (o)
      2'd0: begin p = 6; exp_q = '{1, 1, 1, 1, 1, 0}; end
      2'd1: begin
        p = IRW + 6;
        exp_q = '{1, 1, 0, 0};
        for (int i = 0; i < IRW; i++) exp_q.push_back(i == IRW - 1);
        exp_q.push_back(1); exp_q.push_back(0);
      end
      2'd2: begin
        p = n + 5;
        exp_q = '{1, 0, 0};
        for (int i = 0; i < n; i++) exp_q.push_back(i == n - 1);
        exp_q.push_back(1); exp_q.push_back(0);
      end
      default: p = 0;
    endcase
    // expected architectural effect
    m = (64'd1 << n) - 64'd1;
    case (o)
      2'd0: cur_ir = 8'h00;
      2'd1: begin cur_ir = ir; exp_ir_err = force_cap0; end
      2'd2: exp_dr_out = ((cur_ir == 8'h00) ? IDCODE : {d[30:0], 1'b0}) & m[31:0];
      default: ;
    endcase

    tms_log.delete();
    tdi_bad = 0;
    @(negedge clk);
    b.start = 1'b1; b.op = o; b.ir_in = ir; b.dr_in = d; b.dr_len = len;
    @(negedge clk);
    b.start = 1'b0; b.op = 2'($urandom); b.ir_in = 8'($urandom);
    b.dr_in = $urandom; b.dr_len = 6'($urandom);
    cyc = 0; busy_clks = 0;
    while (b.done !== 1'b1 && cyc < 4000) begin
      if (b.busy === 1'b1) busy_clks++;
      if (poke && cyc == 20) begin b.start = 1'b1; b.op = 2'd0; end
      if (poke && cyc == 21) b.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 64'(cyc < 4000), 64'd1);
    check("busy_at_done", 64'(b.busy), 64'd0);
    if (o == 2'd3) begin
      check("nop_latency", 64'(cyc), 64'd1);
      check("nop_no_tck", 64'(tms_log.size()), 64'd0);
    end else begin
      diff = busy_clks - 2 * int'(CLK_DIV) * p;
      if (diff < -1 || diff > 1) check("busy_clks", 64'(busy_clks), 64'(2 * int'(CLK_DIV) * p));
      else check("busy_clks_tol", 64'(busy_clks - diff), 64'(2 * int'(CLK_DIV) * p));
      check("tck_periods", 64'(tms_log.size()), 64'(p));
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < tms_log.size(); i++)
        if (tms_log[i] != exp_q[i]) bad++;
      check("tms_seq_bad", 64'(bad), 64'd0);
      check("tdi_idle_bad", 64'(tdi_bad), 64'd0);
      check("tap_in_rti", 64'(tap), 64'(RTI));
      if (o == 2'd1) check("tap_ir", 64'(ir_reg), 64'(ir));
    end
    check("dr_out", 64'(b.dr_out), 64'(exp_dr_out));
`ifdef JTAG_HOST_IR_CHECK_EN
    check("ir_err", 64'(b.ir_err), 64'(exp_ir_err));
`endif
    @(negedge clk);
    check("done_pulse_1clk", 64'(b.done), 64'd0);
  endtask

  initial begin
    int done_cnt;
    logic [7:0] rir;
    rst = 1'b1;
    b.start = 1'b0; b.op = 2'd0; b.ir_in = '0; b.dr_in = '0; b.dr_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(b.busy), 64'd0);
    check("rst_done", 64'(b.done), 64'd0);
    check("rst_dr_out", 64'(b.dr_out), 64'd0);
    check("rst_tck", 64'(b.tck), 64'd0);
    check("rst_tms", 64'(b.tms), 64'd1);
    check("rst_tdi", 64'(b.tdi), 64'd0);
`ifdef JTAG_HOST_IR_CHECK_EN
    check("rst_ir_err", 64'(b.ir_err), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd0, 8'h00, 32'h0, 6'd0, 1'b0);
    run_op(2'd1, 8'h00, 32'h0, 6'd0, 1'b0);
    run_op(2'd2, 8'h00, $urandom, 6'd32, 1'b0);
    check("idcode_const", 64'(b.dr_out), 64'h1234_5679);

    run_op(2'd1, 8'hFF, 32'h0, 6'd0, 1'b0);
    run_op(2'd2, 8'h00, 32'h0000_00A5, 6'd8, 1'b0);
    check("bypass_a5", 64'(b.dr_out), 64'h4A);

    run_op(2'd3, 8'h00, 32'h0, 6'd0, 1'b0);

    // dr_len=0 acts as 1, dr_len>DR_MAX acts as DR_MAX
    run_op(2'd1, 8'h00, 32'h0, 6'd0, 1'b0);
    run_op(2'd2, 8'h00, $urandom, 6'd0, 1'b0);
    run_op(2'd2, 8'h00, $urandom, 6'd40, 1'b0);

    // start while busy must be ignored
    run_op(2'd1, 8'hFF, 32'h0, 6'd0, 1'b0);
    run_op(2'd2, 8'h00, $urandom, 6'd16, 1'b1);
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (b.busy !== 1'b0 || b.done !== 1'b0) done_cnt++;
    end
    check("no_late_start", 64'(done_cnt), 64'd0);

    // randomized IR/DR sequences
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: rir = 8'h00;
        1: rir = 8'hFF;
        default: rir = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) run_op(2'd1, rir, 32'h0, 6'd0, 1'b0);
      run_op(2'd2, 8'h00, $urandom, 6'($urandom_range(0, 40)), 1'b0);
    end

    // async reset mid DR scan
    @(negedge clk);
    b.start = 1'b1; b.op = 2'd2; b.dr_len = 6'd32; b.dr_in = $urandom;
    @(negedge clk);
    b.start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_tck", 64'(b.tck), 64'd0);
    check("abort_tms", 64'(b.tms), 64'd1);
    check("abort_busy", 64'(b.busy), 64'd0);
    check("abort_done", 64'(b.done), 64'd0);
    check("abort_dr_out", 64'(b.dr_out), 64'd0);
    exp_dr_out = 32'h0;
    exp_ir_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (b.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run_op(2'd0, 8'h00, 32'h0, 6'd0, 1'b0);
    run_op(2'd2, 8'h00, $urandom, 6'd32, 1'b0);

`ifdef JTAG_HOST_IR_CHECK_EN
    force_cap0 = 1'b0;
    run_op(2'd1, 8'h00, 32'h0, 6'd0, 1'b0);
    force_cap0 = 1'b1;
    run_op(2'd1, 8'h00, 32'h0, 6'd0, 1'b0);
    force_cap0 = 1'b0;
    run_op(2'd2, 8'h00, $urandom, 6'd12, 1'b0);
    run_op(2'd1, 8'hFF, 32'h0, 6'd0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
